// File: rtl/spi_mem_arbiter_if.sv
// Bundle of the arbiter's request/response ports and its byte-engine link.
// "master" is the environment side: the two requesters plus the SPI byte engine.
// "slave" is the arbiter itself.
interface spi_mem_arbiter_if;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_word;
  logic        f_ack;
  logic [15:0] f_rdata;

  logic        d_req;
  logic [15:0] d_addr;
  logic        d_word;
  logic        d_ack;
  logic [15:0] d_rdata;

  logic        err;

  logic        eng_start;
  logic [15:0] eng_addr;
  logic        eng_busy;
  logic        eng_done;
  logic [7:0]  eng_data;

  modport master (
    output f_req, f_addr, f_word, d_req, d_addr, d_word,
           eng_busy, eng_done, eng_data,
    input  f_ack, f_rdata, d_ack, d_rdata, err, eng_start, eng_addr
  );

  modport slave (
    input  f_req, f_addr, f_word, d_req, d_addr, d_word,
           eng_busy, eng_done, eng_data,
    output f_ack, f_rdata, d_ack, d_rdata, err, eng_start, eng_addr
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one SPI byte-read engine between the fetch
// and data ports. Word requests issue two byte reads (addr, addr+1) and are
// assembled little-endian. A watchdog turns a missing eng_done into an
// acknowledged error. All outputs come straight from flops.
module spi_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_n;
  logic          gnt_d_q, gnt_d_n;
  logic          last_d_q, last_d_n;
  logic [15:0]   addr_q, addr_n;
  logic          word_q, word_n;
  logic          idx_q, idx_n;
  logic [TW-1:0] wd_q, wd_n;
  logic [15:0]   res_q, res_n;
  logic          eng_start_q, eng_start_n;
  logic [15:0]   eng_addr_q, eng_addr_n;
  logic          f_ack_q, f_ack_n;
  logic          d_ack_q, d_ack_n;
  logic [15:0]   f_rdata_q, f_rdata_n;
  logic [15:0]   d_rdata_q, d_rdata_n;
  logic          err_q, err_n;
  logic          go_resp;
  logic [15:0]   rdata_v;

  // State and every registered output; last_grant resets to DATA so fetch wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_d_q     <= 1'b0;
      last_d_q    <= 1'b1;
      addr_q      <= 16'h0000;
      word_q      <= 1'b0;
      idx_q       <= 1'b0;
      wd_q        <= '0;
      res_q       <= 16'h0000;
      eng_start_q <= 1'b0;
      eng_addr_q  <= 16'h0000;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      f_rdata_q   <= 16'h0000;
      d_rdata_q   <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      gnt_d_q     <= gnt_d_n;
      last_d_q    <= last_d_n;
      addr_q      <= addr_n;
      word_q      <= word_n;
      idx_q       <= idx_n;
      wd_q        <= wd_n;
      res_q       <= res_n;
      eng_start_q <= eng_start_n;
      eng_addr_q  <= eng_addr_n;
      f_ack_q     <= f_ack_n;
      d_ack_q     <= d_ack_n;
      f_rdata_q   <= f_rdata_n;
      d_rdata_q   <= d_rdata_n;
      err_q       <= err_n;
    end
  end

  // Next-state logic; strobes (eng_start, acks) are computed one cycle ahead so they leave flops.
  always_comb begin
    state_n     = state_q;
    gnt_d_n     = gnt_d_q;
    last_d_n    = last_d_q;
    addr_n      = addr_q;
    word_n      = word_q;
    idx_n       = idx_q;
    wd_n        = wd_q;
    res_n       = res_q;
    eng_start_n = 1'b0;
    eng_addr_n  = eng_addr_q;
    f_ack_n     = 1'b0;
    d_ack_n     = 1'b0;
    f_rdata_n   = f_rdata_q;
    d_rdata_n   = d_rdata_q;
    err_n       = err_q;
    go_resp     = 1'b0;
    rdata_v     = 16'h0000;

    case (state_q)
      IDLE: begin
        if ((bus.f_req || bus.d_req) && !bus.eng_busy) begin
          gnt_d_n     = (bus.f_req && bus.d_req) ? !last_d_q : bus.d_req;
          addr_n      = gnt_d_n ? bus.d_addr : bus.f_addr;
          word_n      = gnt_d_n ? bus.d_word : bus.f_word;
          idx_n       = 1'b0;
          err_n       = 1'b0;
          res_n       = 16'h0000;
          eng_start_n = 1'b1;
          eng_addr_n  = addr_n;
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        wd_n    = '0;
        state_n = WAIT;
      end
      WAIT: begin
        wd_n = wd_q + 1'b1;
        if (bus.eng_done) begin
          if (idx_q) begin
            res_n[15:8] = bus.eng_data;
          end else begin
            res_n[7:0] = bus.eng_data;
          end
          if (word_q && !idx_q) begin
            idx_n       = 1'b1;
            eng_start_n = 1'b1;
            eng_addr_n  = addr_q + 16'd1;
            state_n     = ISSUE;
          end else begin
            go_resp = 1'b1;
          end
        end else if (wd_q == TW'(TIMEOUT_CYCLES)) begin
          err_n   = 1'b1;
          go_resp = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (go_resp) begin
      state_n  = RESP;
      last_d_n = gnt_d_q;
      rdata_v  = word_q ? res_n : {8'h00, res_n[7:0]};
      if (gnt_d_q) begin
        d_ack_n   = 1'b1;
        d_rdata_n = rdata_v;
      end else begin
        f_ack_n   = 1'b1;
        f_rdata_n = rdata_v;
      end
    end
  end

  assign bus.f_ack     = f_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_addr  = eng_addr_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: a byte-engine model backed by a random memory
// image, per-port expected-response queues filled when requests are issued,
// and a monitor that pops and compares whenever an ack appears.
module tb_spi_mem_arbiter;

  localparam int TO       = 20;
  localparam int HANG_LEN = 35;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  spi_mem_arbiter_if bus();

  spi_mem_arbiter #(.TIMEOUT_CYCLES(TO), .TW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          n_starts = 0;
  logic [7:0]  mem [0:65535];
  logic [15:0] start_log[$];
  bit          grant_log[$];
  exp_t        f_q[$];
  exp_t        d_q[$];
  bit          hang = 1'b0;
  int          fix_lat = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference read: little-endian word from the memory image, addresses wrap at 16 bits.
  function automatic logic [15:0] refRead(input logic [15:0] a, input bit w);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return w ? {mem[a1], mem[a]} : {8'h00, mem[a]};
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_f_ack"},     32'(bus.f_ack),     32'd0);
    checkOutput({tag, "_d_ack"},     32'(bus.d_ack),     32'd0);
    checkOutput({tag, "_eng_start"}, 32'(bus.eng_start), 32'd0);
    checkOutput({tag, "_err"},       32'(bus.err),       32'd0);
    checkOutput({tag, "_f_rdata"},   32'(bus.f_rdata),   32'd0);
    checkOutput({tag, "_d_rdata"},   32'(bus.d_rdata),   32'd0);
    checkOutput({tag, "_eng_addr"},  32'(bus.eng_addr),  32'd0);
  endtask

  // Issue one request on a port, queue its expected response, hold it until the ack, then idle a cycle.
  task automatic applyStimulus(input bit is_d, input logic [15:0] a, input bit w, input bit to);
    exp_t e;
    bit   got;
    e.rdata = to ? 16'h0000 : refRead(a, w);
    e.err   = to;
    if (is_d) begin
      d_q.push_back(e);
      bus.d_addr = a;
      bus.d_word = w;
      bus.d_req  = 1'b1;
    end else begin
      f_q.push_back(e);
      bus.f_addr = a;
      bus.f_word = w;
      bus.f_req  = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (is_d ? bus.d_ack : bus.f_ack) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput(is_d ? "d_ack_seen" : "f_ack_seen", 32'(got), 32'd1);
    if (is_d) bus.d_req = 1'b0;
    else      bus.f_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAck(input bit is_d);
    exp_t        e;
    logic [15:0] act;
    int          n;
    act = is_d ? bus.d_rdata : bus.f_rdata;
    n   = is_d ? d_q.size() : f_q.size();
    grant_log.push_back(is_d);
    if (n == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected_ack port=%0d rdata=0x%0h expected no ack", is_d, act);
      return;
    end
    if (is_d) e = d_q.pop_front();
    else      e = f_q.pop_front();
    checkOutput(is_d ? "d_rdata" : "f_rdata", 32'(act), 32'(e.rdata));
    checkOutput("err", 32'(bus.err), 32'(e.err));
    if (e.err) checkOutput("timeout_latency", cyc - start_cyc, TO + 2);
    else       checkOutput("ack_latency", cyc - done_cyc, 1);
  endtask

  // Monitor: samples just after each rising edge and scores acks and engine starts.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (bus.f_ack || bus.d_ack) checkOutput("ack_overlap", 32'(bus.f_ack & bus.d_ack), 32'd0);
    if (bus.f_ack) checkAck(1'b0);
    if (bus.d_ack) checkAck(1'b1);
    if (bus.eng_start) checkOutput("start_while_busy", 32'(bus.eng_busy), 32'd0);
  end

  // Byte engine model: random 1..8 cycle latency, or a hang that stays busy without done.
  initial begin
    int          cnt;
    logic [15:0] e_addr;
    bit          e_hang;
    cnt = 0;
    e_addr = 16'h0000;
    e_hang = 1'b0;
    bus.eng_busy = 1'b0;
    bus.eng_done = 1'b0;
    bus.eng_data = 8'h00;
    forever begin
      @(negedge clk);
      bus.eng_done = 1'b0;
      if (!rst_n) begin
        bus.eng_busy = 1'b0;
        cnt = 0;
      end else if (bus.eng_start) begin
        bus.eng_busy = 1'b1;
        e_addr = bus.eng_addr;
        e_hang = hang;
        start_cyc = cyc;
        n_starts++;
        start_log.push_back(bus.eng_addr);
        cnt = hang ? HANG_LEN : (fix_lat != 0 ? fix_lat : int'($urandom_range(1, 8)));
      end else if (bus.eng_busy) begin
        cnt--;
        if (cnt == 0) begin
          bus.eng_busy = 1'b0;
          if (!e_hang) begin
            bus.eng_done = 1'b1;
            bus.eng_data = mem[e_addr];
            done_cyc = cyc;
          end
        end
      end
    end
  end

  // Directed scenarios followed by randomized two-port traffic.
  initial begin
    int s0;
    int hang_start;
    bit exp_order [4];
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h1234] = 8'hA5;
    mem[16'h0100] = 8'h34;
    mem[16'h0101] = 8'h12;
    bus.f_req = 1'b0; bus.f_addr = 16'h0000; bus.f_word = 1'b0;
    bus.d_req = 1'b0; bus.d_addr = 16'h0000; bus.d_word = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");

    grant_log.delete();
    rst_n = 1'b1;
    fork
      begin
        applyStimulus(1'b0, 16'($urandom), 1'($urandom), 1'b0);
        applyStimulus(1'b0, 16'($urandom), 1'($urandom), 1'b0);
      end
      begin
        applyStimulus(1'b1, 16'($urandom), 1'($urandom), 1'b0);
        applyStimulus(1'b1, 16'($urandom), 1'($urandom), 1'b0);
      end
    join
    checkOutput("contention_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) checkOutput("contention_order", 32'(grant_log[i]), 32'(exp_order[i]));

    s0 = n_starts;
    start_log.delete();
    applyStimulus(1'b0, 16'h1234, 1'b0, 1'b0);
    checkOutput("byte_starts", n_starts - s0, 1);
    if (start_log.size() > 0) checkOutput("byte_addr", 32'(start_log[0]), 32'h1234);
    checkOutput("byte_rdata", 32'(bus.f_rdata), 32'h00A5);

    s0 = n_starts;
    start_log.delete();
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0);
    checkOutput("word_starts", n_starts - s0, 2);
    if (start_log.size() > 1) begin
      checkOutput("word_addr0", 32'(start_log[0]), 32'h0100);
      checkOutput("word_addr1", 32'(start_log[1]), 32'h0101);
    end
    checkOutput("word_rdata", 32'(bus.d_rdata), 32'h1234);

    start_log.delete();
    applyStimulus(1'b0, 16'hFFFF, 1'b1, 1'b0);
    if (start_log.size() > 1) checkOutput("wrap_addr1", 32'(start_log[1]), 32'h0000);
    checkOutput("wrap_rdata", 32'(bus.f_rdata), 32'({mem[16'h0000], mem[16'hFFFF]}));

    fork
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        applyStimulus(1'b0, 16'($urandom), 1'($urandom), 1'b0);
      end
      for (int j = 0; j < 12; j++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        applyStimulus(1'b1, 16'($urandom), 1'($urandom), 1'b0);
      end
    join

    hang = 1'b1;
    applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b1);
    hang = 1'b0;
    hang_start = start_cyc;
    checkOutput("timeout_rdata", 32'(bus.d_rdata), 32'h0000);
    applyStimulus(1'b0, 16'($urandom), 1'b1, 1'b0);
    checkOutput("blocked_while_busy", 32'(start_cyc >= hang_start + HANG_LEN + 1), 32'd1);

    fix_lat = 15;
    s0 = n_starts;
    bus.d_addr = 16'h2000;
    bus.d_word = 1'b1;
    bus.d_req  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (n_starts - s0 >= 2) break;
      @(posedge clk);
      #1;
    end
    checkOutput("midreset_second_issue", n_starts - s0, 2);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clk);
    #1;
    checkAllZero("midreset");
    rst_n = 1'b1;
    fix_lat = 0;
    applyStimulus(1'b1, 16'h2000, 1'b1, 1'b0);
    checkOutput("after_reset_rdata", 32'(bus.d_rdata), 32'({mem[16'h2001], mem[16'h2000]}));

    repeat (5) begin @(posedge clk); #1; end
    checkOutput("f_queue_empty", f_q.size(), 0);
    checkOutput("d_queue_empty", d_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
